// File: rtl/pic_cmd_sequencer_pkg.sv
// rtl/pic_cmd_sequencer_pkg.sv - ICW FSM states, command codes and ICW/OCW bit positions
package pic_cmd_sequencer_pkg;

   typedef enum logic [2:0] {
      UNINIT = 3'd0,
      W_ICW2 = 3'd1,
      W_ICW3 = 3'd2,
      W_ICW4 = 3'd3,
      READY  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CMD_ICW1 = 2'd0,
      CMD_OCW2 = 2'd1,
      CMD_OCW3 = 2'd2,
      CMD_A0   = 2'd3
   } cmd_t;

   localparam int CMD_D3    = 3;
   localparam int CMD_D4    = 4;
   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;
   localparam int ICW4_UPM  = 0;
   localparam int ICW4_AEOI = 1;
   localparam int ICW4_MS   = 2;
   localparam int ICW4_BUF  = 3;
   localparam int ICW4_SFNM = 4;
   localparam int OCW3_RIS  = 0;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_P    = 2;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/pic_cmd_decode.sv
// rtl/pic_cmd_decode.sv - classifies a written byte as ICW1, OCW2, OCW3 or an a0=1 write
module pic_cmd_decode
   import pic_cmd_sequencer_pkg::*;
(
   input  logic a0,
   input  logic d4,
   input  logic d3,
   output cmd_t cmd
);

   always_comb begin
      cmd = CMD_OCW2;
      if (a0)
         cmd = CMD_A0;
      else if (d4)
         cmd = CMD_ICW1;
      else if (d3)
         cmd = CMD_OCW3;
   end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// rtl/pic_cmd_sequencer.sv - PIC read/write sequencer, ICW init FSM and mask/mode registers
// Optional poll command support is built when POLL_CMD_EN is defined.
module pic_cmd_sequencer
   import pic_cmd_sequencer_pkg::*;
#(
   parameter logic [7:0] IMR_INIT = 8'h00,
   parameter logic [4:0] VEC_RST  = 5'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   input  logic [7:0] irr,
   input  logic [7:0] isr,
   input  logic [7:0] poll_byte,
   output logic       rd_flag,
   output logic       wr_flag,
   output logic [7:0] dout,
   output logic       init_done,
   output logic       ltim,
   output logic       sngl,
   output logic       ic4,
   output logic [4:0] vec_base,
   output logic [7:0] icw3,
   output logic       aeoi,
   output logic       sfnm,
   output logic       buf_mode,
   output logic       ms,
   output logic       upm,
   output logic [7:0] imr,
   output logic [2:0] ocw2_cmd,
   output logic [2:0] ocw2_lvl,
   output logic       ocw2_vld,
   output logic       read_isr,
   output logic       smm,
   output logic       poll_ack
);

   logic       rd_req, wr_req, wr_flag_d, wa0, commit;
   logic [7:0] wdin, lo_byte;
   cmd_t       cmd;
   state_t     state, state_nx;
   logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, ld_ocw2, ld_ocw3;

   assign rd_req = ~cs_n & ~rd_n & wr_n;
   assign wr_req = ~cs_n & ~wr_n & rd_n;
   // A write commits once its strobe has ended, from the bytes held during the last wr_flag cycle.
   assign commit = wr_flag_d & ~wr_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_flag   <= 1'b0;
         wr_flag   <= 1'b0;
         wr_flag_d <= 1'b0;
         wa0       <= 1'b0;
         wdin      <= 8'h00;
      end else begin
         rd_flag   <= rd_req;
         wr_flag   <= wr_req;
         wr_flag_d <= wr_flag;
         if (wr_flag) begin
            wa0  <= a0;
            wdin <= din;
         end
      end
   end

   pic_cmd_decode u_decode (
      .a0  (wa0),
      .d4  (wdin[CMD_D4]),
      .d3  (wdin[CMD_D3]),
      .cmd (cmd)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= UNINIT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (commit) begin
         if (cmd == CMD_ICW1) begin
            state_nx = W_ICW2;
         end else if (cmd == CMD_A0) begin
            case (state)
               W_ICW2:  state_nx = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : READY);
               W_ICW3:  state_nx = ic4 ? W_ICW4 : READY;
               W_ICW4:  state_nx = READY;
               default: state_nx = state;
            endcase
         end
      end
   end

   always_comb begin
      init_done = (state == READY);
      ld_icw1   = commit && (cmd == CMD_ICW1);
      ld_icw2   = commit && (cmd == CMD_A0)   && (state == W_ICW2);
      ld_icw3   = commit && (cmd == CMD_A0)   && (state == W_ICW3);
      ld_icw4   = commit && (cmd == CMD_A0)   && (state == W_ICW4);
      ld_ocw1   = commit && (cmd == CMD_A0)   && (state == READY);
      ld_ocw2   = commit && (cmd == CMD_OCW2) && (state == READY);
      ld_ocw3   = commit && (cmd == CMD_OCW3) && (state == READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ltim     <= 1'b0;
         sngl     <= 1'b0;
         ic4      <= 1'b0;
         vec_base <= VEC_RST;
         icw3     <= 8'h00;
         aeoi     <= 1'b0;
         sfnm     <= 1'b0;
         buf_mode <= 1'b0;
         ms       <= 1'b0;
         upm      <= 1'b0;
         imr      <= IMR_INIT;
         ocw2_cmd <= 3'b000;
         ocw2_lvl <= 3'b000;
         ocw2_vld <= 1'b0;
         read_isr <= 1'b0;
         smm      <= 1'b0;
         dout     <= 8'h00;
      end else begin
         ocw2_vld <= ld_ocw2;
         dout     <= a0 ? imr : lo_byte;
         if (ld_icw1) begin
            ltim     <= wdin[ICW1_LTIM];
            sngl     <= wdin[ICW1_SNGL];
            ic4      <= wdin[ICW1_IC4];
            aeoi     <= 1'b0;
            sfnm     <= 1'b0;
            buf_mode <= 1'b0;
            ms       <= 1'b0;
            upm      <= 1'b0;
            imr      <= IMR_INIT;
            smm      <= 1'b0;
            read_isr <= 1'b0;
         end
         if (ld_icw2)
            vec_base <= wdin[7:3];
         if (ld_icw3)
            icw3 <= wdin;
         if (ld_icw4) begin
            sfnm     <= wdin[ICW4_SFNM];
            buf_mode <= wdin[ICW4_BUF];
            ms       <= wdin[ICW4_MS];
            aeoi     <= wdin[ICW4_AEOI];
            upm      <= wdin[ICW4_UPM];
         end
         if (ld_ocw1)
            imr <= wdin;
         if (ld_ocw2) begin
            ocw2_cmd <= wdin[7:5];
            ocw2_lvl <= wdin[2:0];
         end
         if (ld_ocw3) begin
            if (wdin[OCW3_RR])
               read_isr <= wdin[OCW3_RIS];
            if (wdin[OCW3_ESMM])
               smm <= wdin[OCW3_SMM];
         end
      end
   end

`ifdef POLL_CMD_EN
   logic poll_pend;

   // The poll read is consumed on the edge where its rd_flag drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         poll_pend <= 1'b0;
         poll_ack  <= 1'b0;
      end else begin
         poll_ack <= 1'b0;
         if (ld_icw1) begin
            poll_pend <= 1'b0;
         end else if (ld_ocw3 && wdin[OCW3_P]) begin
            poll_pend <= 1'b1;
         end else if (poll_pend && rd_flag && !rd_req && !a0) begin
            poll_pend <= 1'b0;
            poll_ack  <= 1'b1;
         end
      end
   end

   assign lo_byte = poll_pend ? poll_byte : (read_isr ? isr : irr);
`else
   logic unused_poll;

   assign unused_poll = ^poll_byte;
   assign poll_ack    = 1'b0;
   assign lo_byte     = read_isr ? isr : irr;
`endif

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb/tb_pic_cmd_sequencer.sv - directed and randomized checks of pic_cmd_sequencer against a transaction-level model
module tb_pic_cmd_sequencer;

   localparam logic [7:0] IMR_INIT = 8'h3C;
   localparam logic [4:0] VEC_RST  = 5'h11;

   logic       clk = 1'b0;
   logic       rst, cs_n, rd_n, wr_n, a0;
   logic [7:0] din, irr, isr, poll_byte;
   logic       rd_flag, wr_flag, init_done, ltim, sngl, ic4;
   logic       aeoi, sfnm, buf_mode, ms, upm, ocw2_vld, read_isr, smm, poll_ack;
   logic [7:0] dout, icw3, imr;
   logic [4:0] vec_base;
   logic [2:0] ocw2_cmd, ocw2_lvl;

   int vectors = 0;
   int errors  = 0;

   // model state: phase 0 = uninitialised, 2/3/4 = awaiting that ICW, 5 = ready
   int         m_phase;
   bit         m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_buf, m_ms, m_upm, m_ris, m_smm, m_poll;
   logic [4:0] m_vec;
   logic [7:0] m_icw3, m_imr;
   logic [2:0] m_cmd, m_lvl;

   pic_cmd_sequencer #(.IMR_INIT(IMR_INIT), .VEC_RST(VEC_RST)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
      .din(din), .irr(irr), .isr(isr), .poll_byte(poll_byte),
      .rd_flag(rd_flag), .wr_flag(wr_flag), .dout(dout), .init_done(init_done),
      .ltim(ltim), .sngl(sngl), .ic4(ic4), .vec_base(vec_base), .icw3(icw3),
      .aeoi(aeoi), .sfnm(sfnm), .buf_mode(buf_mode), .ms(ms), .upm(upm),
      .imr(imr), .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl), .ocw2_vld(ocw2_vld),
      .read_isr(read_isr), .smm(smm), .poll_ack(poll_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      {m_ltim, m_sngl, m_ic4, m_aeoi, m_sfnm, m_buf, m_ms, m_upm} = '0;
      m_ris = 0; m_smm = 0; m_poll = 0;
      m_vec = VEC_RST; m_icw3 = 8'h00; m_imr = IMR_INIT;
      m_cmd = 3'b000; m_lvl = 3'b000;
   endtask

   task automatic model_write(input logic a0v, input logic [7:0] d, output bit ocw2_hit);
      ocw2_hit = 0;
      if (!a0v && d[4]) begin
         m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
         {m_aeoi, m_sfnm, m_buf, m_ms, m_upm} = '0;
         m_imr = IMR_INIT; m_smm = 0; m_ris = 0; m_poll = 0;
         m_phase = 2;
      end else if (a0v) begin
         case (m_phase)
            2: begin
               m_vec = d[7:3];
               m_phase = !m_sngl ? 3 : (m_ic4 ? 4 : 5);
            end
            3: begin
               m_icw3 = d;
               m_phase = m_ic4 ? 4 : 5;
            end
            4: begin
               m_sfnm = d[4]; m_buf = d[3]; m_ms = d[2]; m_aeoi = d[1]; m_upm = d[0];
               m_phase = 5;
            end
            5: m_imr = d;
            default: ;
         endcase
      end else if (m_phase == 5) begin
         if (!d[3]) begin
            m_cmd = d[7:5]; m_lvl = d[2:0]; ocw2_hit = 1;
         end else begin
            if (d[1]) m_ris = d[0];
            if (d[6]) m_smm = d[5];
`ifdef POLL_CMD_EN
            if (d[2]) m_poll = 1;
`endif
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".init_done"}, init_done, m_phase == 5);
      check({tag, ".icw1"}, {ltim, sngl, ic4}, {m_ltim, m_sngl, m_ic4});
      check({tag, ".vec_base"}, vec_base, m_vec);
      check({tag, ".icw3"}, icw3, m_icw3);
      check({tag, ".icw4"}, {sfnm, buf_mode, ms, aeoi, upm}, {m_sfnm, m_buf, m_ms, m_aeoi, m_upm});
      check({tag, ".imr"}, imr, m_imr);
      check({tag, ".ocw2"}, {ocw2_cmd, ocw2_lvl}, {m_cmd, m_lvl});
      check({tag, ".read_isr"}, read_isr, m_ris);
      check({tag, ".smm"}, smm, m_smm);
   endtask

   task automatic cpu_write(input string tag, input logic a0v, input logic [7:0] d);
      bit hit;
      cs_n = 0; wr_n = 0; a0 = a0v; din = d;
      @(posedge clk); #1;
      check({tag, ".wr_flag"}, {wr_flag, rd_flag}, 2'b10);
      cs_n = 1; wr_n = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_write(a0v, d, hit);
      check({tag, ".ocw2_vld"}, ocw2_vld, hit);
      check_all(tag);
      @(posedge clk); #1;
      check({tag, ".ocw2_vld_off"}, ocw2_vld, 1'b0);
   endtask

   task automatic cpu_read(input string tag, input logic a0v);
      logic [7:0] exp;
      bit         ack;
      cs_n = 0; rd_n = 0; a0 = a0v;
      exp = a0v ? m_imr : (m_poll ? poll_byte : (m_ris ? isr : irr));
      @(posedge clk); #1;
      check({tag, ".rd_flag"}, {rd_flag, wr_flag}, 2'b10);
      check({tag, ".dout"}, dout, exp);
      cs_n = 1; rd_n = 1;
      @(posedge clk); #1;
      ack = m_poll && !a0v;
      if (ack) m_poll = 0;
      check({tag, ".poll_ack"}, poll_ack, ack);
      @(posedge clk); #1;
      check({tag, ".poll_ack_off"}, poll_ack, 1'b0);
   endtask

   initial begin
      bit hit;
      rst = 1; cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0;
      din = 8'h00; irr = 8'h00; isr = 8'h00; poll_byte = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.flags", {rd_flag, wr_flag, ocw2_vld, poll_ack}, 4'b0000);
      check("reset.dout", dout, 8'h00);
      check_all("reset");
      rst = 0;
      @(posedge clk); #1;

      cpu_write("uninit_a0", 1'b1, 8'hFF);
      cpu_write("t1_icw1", 1'b0, 8'h12);
      cpu_write("t1_icw2", 1'b1, 8'h40);
      check("t1.vec", vec_base, 5'h08);

      cpu_write("t2_icw1", 1'b0, 8'h11);
      cpu_write("t2_icw2", 1'b1, 8'h20);
      cpu_write("t2_icw3", 1'b1, 8'h04);
      check("t2.not_done", init_done, 1'b0);
      cpu_write("t2_icw4", 1'b1, 8'h03);
      check("t2.fields", {icw3, aeoi, upm, init_done}, {8'h04, 3'b111});

      cpu_write("t3_ocw1", 1'b1, 8'hA5);
      cpu_read("t3_rd", 1'b1);

      irr = 8'h81; isr = 8'h02;
      cpu_write("t4_ocw3_isr", 1'b0, 8'h0B);
      cpu_read("t4_rd_isr", 1'b0);
      cpu_write("t4_ocw3_irr", 1'b0, 8'h0A);
      cpu_read("t4_rd_irr", 1'b0);

      cpu_write("t5_ocw2", 1'b0, 8'h20);
      cpu_write("t5_icw1", 1'b0, 8'h13);
      cpu_write("t5_ocw2_ignored", 1'b0, 8'hE7);
      cpu_write("t5_icw2", 1'b1, 8'h48);
      cpu_write("t5_icw4", 1'b1, 8'h1F);

      poll_byte = 8'h85;
      cpu_write("t6_ocw3_poll", 1'b0, 8'h0C);
      cpu_read("t6_rd_poll", 1'b0);
      cpu_read("t6_rd_after", 1'b0);

      cs_n = 0; rd_n = 0; wr_n = 0; a0 = 1; din = ~m_imr;
      @(posedge clk); #1;
      check("both_low.flags", {rd_flag, wr_flag}, 2'b00);
      cs_n = 1; rd_n = 1; wr_n = 1;
      repeat (3) @(posedge clk);
      #1;
      check_all("both_low");

      // two writes separated by a single idle strobe cycle
      cs_n = 0; wr_n = 0; a0 = 1; din = 8'h33;
      @(posedge clk); #1;
      wr_n = 1;
      @(posedge clk); #1;
      wr_n = 0; a0 = 0; din = 8'h6B;
      @(posedge clk); #1;
      wr_n = 1; cs_n = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      model_write(1'b1, 8'h33, hit);
      model_write(1'b0, 8'h6B, hit);
      check_all("b2b");

      // reset lands on the edge that would commit the write
      cs_n = 0; wr_n = 0; a0 = 1; din = 8'h77;
      @(posedge clk); #1;
      cs_n = 1; wr_n = 1;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      check("midrst.dout", dout, 8'h00);
      check_all("midrst");
      repeat (3) @(posedge clk);
      #1;
      check_all("midrst_after");

      for (int i = 0; i < 40; i++) begin
         int         op;
         logic [7:0] d;
         op = (m_phase != 5) ? 4 : int'($urandom_range(5, 0));
         irr = 8'($urandom_range(255)); isr = 8'($urandom_range(255));
         poll_byte = 8'($urandom_range(255));
         case (op)
            0: cpu_write("rnd_ocw1", 1'b1, 8'($urandom_range(255)));
            1: begin
               d = 8'($urandom_range(255)); d[4] = 0; d[3] = 0;
               cpu_write("rnd_ocw2", 1'b0, d);
            end
            2: begin
               d = 8'($urandom_range(255)); d[7] = 0; d[4] = 0; d[3] = 1;
               cpu_write("rnd_ocw3", 1'b0, d);
            end
            3: cpu_read("rnd_rd_a0", 1'b1);
            4: begin
               d = 8'($urandom_range(255)); d[7:5] = 3'b000; d[4] = 1;
               cpu_write("rnd_icw1", 1'b0, d);
               for (int k = 0; k < 3 && m_phase != 5; k++)
                  cpu_write("rnd_icwn", 1'b1, 8'($urandom_range(255)));
            end
            default: cpu_read("rnd_rd_lo", 1'b0);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
